reg_gather_tree_4_1: RTL and testbench

- Pipelined collection tree; the return-path counterpart of the register fan-out trees.
- Gathers per-PE result lanes back to a single output through balanced registered reduction levels.
- Also collects per-PE done pulses into one all-done pulse.
- Sits between the CGRA PE array outputs and the host/result interface.

---
 rtl/reg_gather_tree_4_1.sv | 92 +++++++++
 tb/tb_reg_gather_tree_4_1.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_gather_tree_4_1.sv
// Pipelined reduction tree: sums the valid lanes over log2(NUM_IN) registered levels
// and gathers per-lane done pulses into a single all-done pulse.
module reg_gather_tree_4_1 #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            done_in,
  input  logic                         clear,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [NUM_IN-1:0]            done_pending,
  output logic                         all_done
);

  localparam int LEVELS = $clog2(NUM_IN);
  localparam int NODES  = 2 * NUM_IN - 1;

  // Nodes are stored level by level: level k starts at 2*NUM_IN - 2*(NUM_IN>>k).
  logic                  v_q [NODES];
  logic                  v_d [NODES];
  logic [DATA_WIDTH-1:0] d_q [NODES];
  logic [DATA_WIDTH-1:0] d_d [NODES];

  logic [NUM_IN-1:0] done_pending_q, done_pending_d;
  logic              all_done_q, all_done_d;
  logic [NUM_IN-1:0] done_next;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_leaf
      assign v_d[gi] = in_valid[gi];
      assign d_d[gi] = in_valid[gi] ? in_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    for (gi = 1; gi <= LEVELS; gi++) begin : g_lvl
      for (gj = 0; gj < (NUM_IN >> gi); gj++) begin : g_node
        localparam int N = 2 * NUM_IN - 2 * (NUM_IN >> gi) + gj;
        localparam int C = 2 * NUM_IN - 2 * (NUM_IN >> (gi - 1)) + 2 * gj;
        assign v_d[N] = v_q[C] | v_q[C+1];
        assign d_d[N] = d_q[C] + d_q[C+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NODES; n++) begin
        v_q[n] <= 1'b0;
        d_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NODES; n++) begin
        v_q[n] <= v_d[n];
        d_q[n] <= d_d[n];
      end
    end
  end

  // The completing arrival counts, so the check uses pending OR incoming.
  assign done_next = done_pending_q | done_in;

  always_comb begin
    done_pending_d = done_next;
    all_done_d     = 1'b0;
    if (clear) begin
      done_pending_d = '0;
    end else if (&done_next) begin
      done_pending_d = '0;
      all_done_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_pending_q <= '0;
      all_done_q     <= 1'b0;
    end else begin
      done_pending_q <= done_pending_d;
      all_done_q     <= all_done_d;
    end
  end

  assign out_valid    = v_q[NODES-1];
  assign out_data     = d_q[NODES-1];
  assign done_pending = done_pending_q;
  assign all_done     = all_done_q;

endmodule

// File: tb/tb_reg_gather_tree_4_1.sv
// Randomised and directed bench for reg_gather_tree_4_1 against a history-based sum model.
module tb_reg_gather_tree_4_1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = 4'h0;
  logic [63:0] in_data = '0;
  logic [3:0]  done_in = 4'h0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  done_pending;
  logic        all_done;

  int n_vec = 0;
  int n_err = 0;

  // Model: result of each sampled input set, newest at index 0; output shows index 2.
  logic        hv [3];
  logic [15:0] hs [3];
  logic [3:0]  m_pend;
  logic        m_done;

  reg_gather_tree_4_1 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .done_in(done_in), .clear(clear), .out_valid(out_valid), .out_data(out_data),
    .done_pending(done_pending), .all_done(all_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hv[i] = 1'b0;
      hs[i] = 16'h0;
    end
    m_pend = 4'h0;
    m_done = 1'b0;
  endtask

  task automatic set_lanes(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    in_data = {d, c, b, a};
  endtask

  task automatic tick();
    int sum;
    logic [3:0] nxt;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      sum = 0;
      for (int i = 0; i < 4; i++)
        if (in_valid[i]) sum += int'(in_data[i*16 +: 16]);
      hv[2] = hv[1]; hs[2] = hs[1];
      hv[1] = hv[0]; hs[1] = hs[0];
      hv[0] = |in_valid;
      hs[0] = 16'(sum % 65536);
      nxt = m_pend | done_in;
      if (clear) begin
        m_pend = 4'h0; m_done = 1'b0;
      end else if (nxt == 4'hF) begin
        m_pend = 4'h0; m_done = 1'b1;
      end else begin
        m_pend = nxt; m_done = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    in_valid = 4'hF;
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 16'h0 || done_pending !== 4'h0 || all_done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d: got v=%b d=%h p=%b ad=%b, want all zero",
                 c, out_valid, out_data, done_pending, all_done);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_vec++;
      if (c < 3 && out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release_early edge=%0d: got v=%b, want 0", c, out_valid);
      end else if (c == 3 && (out_valid !== 1'b1 || out_data !== 16'd10)) begin
        n_err++;
        $display("FAIL reset_release_first edge=%0d: got v=%b d=%0d, want v=1 d=10", c, out_valid, out_data);
      end
    end
  endtask

  task automatic test_streaming();
    logic [15:0] want [3];
    want[0] = 16'd10; want[1] = 16'd26; want[2] = 16'h0000;
    in_valid = 4'hF;
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);      tick();
    set_lanes(16'd5, 16'd6, 16'd7, 16'd8);      tick();
    set_lanes(16'hFFFF, 16'd1, 16'd0, 16'd0);   tick();
    in_valid = 4'h0;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== want[c]) begin
        n_err++;
        $display("FAIL stream idx=%0d: got v=%b d=%h, want v=1 d=%h", c, out_valid, out_data, want[c]);
      end
      tick();
    end
  endtask

  task automatic test_partial();
    in_valid = 4'b0101;
    set_lanes(16'd10, 16'd20, 16'd30, 16'd40);
    tick();
    in_valid = 4'b0000;
    tick();
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 16'd40) begin
      n_err++;
      $display("FAIL partial: got v=%b d=%0d, want v=1 d=40", out_valid, out_data);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 16'd0) begin
      n_err++;
      $display("FAIL none_valid: got v=%b d=%0d, want v=0 d=0", out_valid, out_data);
    end
  endtask

  task automatic test_done();
    clear = 1'b1; tick(); clear = 1'b0;
    done_in = 4'b0001; tick();
    done_in = 4'b0000; tick();
    done_in = 4'b0100; tick();
    done_in = 4'b0000;
    n_vec++;
    if (done_pending !== 4'b0101 || all_done !== 1'b0) begin
      n_err++;
      $display("FAIL done_partial: got p=%b ad=%b, want p=0101 ad=0", done_pending, all_done);
    end
    tick(); tick();
    done_in = 4'b1010; tick();
    done_in = 4'b0000;
    n_vec++;
    if (all_done !== 1'b1 || done_pending !== 4'b0000) begin
      n_err++;
      $display("FAIL done_complete: got p=%b ad=%b, want p=0000 ad=1", done_pending, all_done);
    end
    tick();
    n_vec++;
    if (all_done !== 1'b0) begin
      n_err++;
      $display("FAIL done_single_pulse: got ad=%b, want 0", all_done);
    end
    done_in = 4'b0111; tick();
    done_in = 4'b0010; tick();
    n_vec++;
    if (done_pending !== 4'b0111) begin
      n_err++;
      $display("FAIL done_repeat: got p=%b, want 0111", done_pending);
    end
    clear = 1'b1; done_in = 4'b1000; tick();
    clear = 1'b0; done_in = 4'b0000;
    n_vec++;
    if (done_pending !== 4'b0000 || all_done !== 1'b0) begin
      n_err++;
      $display("FAIL clear_priority: got p=%b ad=%b, want p=0000 ad=0", done_pending, all_done);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      set_lanes(16'(c + 1), 16'(c + 2), 16'(c + 3), 16'(c + 4));
      tick();
    end
    done_in = 4'b0011; tick(); done_in = 4'b0000;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || done_pending !== 4'h0 || all_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_immediate: got v=%b d=%h p=%b, want zero", out_valid, out_data, done_pending);
    end
    tick(); tick();
    in_valid = 4'h0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 16'h0) begin
        n_err++;
        $display("FAIL async_reset_stale cyc=%0d: got v=%b d=%h, want v=0 d=0", c, out_valid, out_data);
      end
    end
    in_valid = 4'b1000;
    set_lanes(16'd0, 16'd0, 16'd0, 16'd7);
    tick();
    in_valid = 4'h0;
    tick(); tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 16'd7) begin
      n_err++;
      $display("FAIL async_reset_new: got v=%b d=%0d, want v=1 d=7", out_valid, out_data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++)
        in_data[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                                          : 16'($urandom);
      done_in = 4'($urandom) & 4'($urandom);
      clear   = ($urandom_range(0, 19) == 0);
      tick();
      n_vec++;
      if (out_valid !== hv[2] || out_data !== hs[2]) begin
        n_err++;
        $display("FAIL random_data cyc=%0d: got v=%b d=%h, want v=%b d=%h",
                 c, out_valid, out_data, hv[2], hs[2]);
      end
      n_vec++;
      if (done_pending !== m_pend || all_done !== m_done) begin
        n_err++;
        $display("FAIL random_done cyc=%0d: got p=%b ad=%b, want p=%b ad=%b",
                 c, done_pending, all_done, m_pend, m_done);
      end
    end
    clear = 1'b0;
    done_in = 4'h0;
    in_valid = 4'h0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_partial();
    test_done();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
